// File: rtl/serdiv_pkg.sv
// Shared types and constants for the serial-divider arbiter.
package serdiv_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   typedef logic port_id_t;

   localparam int          DIV0_MAX_W = 64;
   localparam logic [DIV0_MAX_W-1:0] DIV0_QUOT = '1;

endpackage

// File: rtl/serdiv_rr_arb.sv
// Two-way round-robin grant; on a tie the port that did not win last time is chosen.
module serdiv_rr_arb
   import serdiv_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [1:0] i_req,
   input  logic       i_update,
   output logic [1:0] o_grant,
   output port_id_t   o_grant_id
);

   port_id_t r_last_grant;

   always_comb begin
      o_grant_id = 1'b0;
      o_grant    = 2'b00;
      case (i_req)
         2'b01:   o_grant_id = 1'b0;
         2'b10:   o_grant_id = 1'b1;
         2'b11:   o_grant_id = ~r_last_grant;
         default: o_grant_id = 1'b0;
      endcase
      if (i_req != 2'b00) begin
         o_grant = o_grant_id ? 2'b10 : 2'b01;
      end
   end

   // Reset to 1 so that port 0 wins the first tie.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_last_grant <= 1'b1;
      end else if (i_update) begin
         r_last_grant <= o_grant_id;
      end
   end

endmodule

// File: rtl/serdiv_arbiter.sv
// Shares one bit-serial divider core between two requesters, one job at a time.
// Optional WAIT timeout is enabled with `define SERDIV_ARB_TIMEOUT_EN.
module serdiv_arbiter
   import serdiv_pkg::*;
#(
   parameter int WIDTH          = 16,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic             wb_clk_i,
   input  logic             wb_rst_i,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_dividend,
   input  logic [WIDTH-1:0] req0_divisor,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_dividend,
   input  logic [WIDTH-1:0] req1_divisor,
   output logic             rsp0_valid,
   input  logic             rsp0_ready,
   output logic [WIDTH-1:0] rsp0_quot,
   output logic [WIDTH-1:0] rsp0_rem,
   output logic             rsp0_err,
   output logic             rsp1_valid,
   input  logic             rsp1_ready,
   output logic [WIDTH-1:0] rsp1_quot,
   output logic [WIDTH-1:0] rsp1_rem,
   output logic             rsp1_err,
   output logic             div_start,
   output logic [WIDTH-1:0] div_dividend,
   output logic [WIDTH-1:0] div_divisor,
   input  logic             div_done,
   input  logic [WIDTH-1:0] div_quot,
   input  logic [WIDTH-1:0] div_rem,
   output logic [1:0]       o_dbg_state
);

   // Handshakes: a request transfers on the cycle where reqN_valid && reqN_ready;
   // a response transfers on the cycle where rspN_valid && rspN_ready.

   state_t           r_state;
   state_t           w_next_state;
   port_id_t         r_gnt;
   logic [WIDTH-1:0] r_dividend;
   logic [WIDTH-1:0] r_divisor;
   logic [WIDTH-1:0] r_quot;
   logic [WIDTH-1:0] r_rem;
   logic             r_err;

   logic [1:0]       w_grant;
   port_id_t         w_gnt_id;
   logic             w_accept;
   logic [WIDTH-1:0] w_dividend;
   logic [WIDTH-1:0] w_divisor;
   logic             w_div0;
   logic             w_rsp_ready;
   logic             w_timeout;

   serdiv_rr_arb u_arb (
      .i_clk      (wb_clk_i),
      .i_rst      (wb_rst_i),
      .i_req      ({req1_valid, req0_valid}),
      .i_update   (w_accept),
      .o_grant    (w_grant),
      .o_grant_id (w_gnt_id)
   );

   assign w_accept    = (r_state == IDLE) && (w_grant != 2'b00) && !wb_rst_i;
   assign w_dividend  = w_gnt_id ? req1_dividend : req0_dividend;
   assign w_divisor   = w_gnt_id ? req1_divisor  : req0_divisor;
   assign w_div0      = (w_divisor == '0);
   assign w_rsp_ready = r_gnt ? rsp1_ready : rsp0_ready;

`ifdef SERDIV_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] r_tmo_cnt;

   // ISSUE always precedes WAIT, so clearing there gives a zero count on WAIT entry.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         r_tmo_cnt <= '0;
      end else if (r_state == ISSUE) begin
         r_tmo_cnt <= '0;
      end else if (r_state == WAIT) begin
         r_tmo_cnt <= r_tmo_cnt + 1'b1;
      end
   end

   assign w_timeout = (r_state == WAIT) && (r_tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
   logic w_unused_tmo;
   assign w_unused_tmo = (TIMEOUT_CYCLES > 0);
   assign w_timeout    = 1'b0;
`endif

   always_comb begin
      w_next_state = r_state;
      req0_ready   = 1'b0;
      req1_ready   = 1'b0;
      rsp0_valid   = 1'b0;
      rsp1_valid   = 1'b0;
      div_start    = 1'b0;
      case (r_state)
         IDLE: begin
            req0_ready = w_grant[0] && !wb_rst_i;
            req1_ready = w_grant[1] && !wb_rst_i;
            if (w_accept) begin
               w_next_state = w_div0 ? RESP : ISSUE;
            end
         end
         ISSUE: begin
            div_start    = 1'b1;
            w_next_state = WAIT;
         end
         WAIT: begin
            if (div_done || w_timeout) begin
               w_next_state = RESP;
            end
         end
         RESP: begin
            rsp0_valid = (r_gnt == 1'b0);
            rsp1_valid = (r_gnt == 1'b1);
            if (w_rsp_ready) begin
               w_next_state = IDLE;
            end
         end
         default: w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         r_state    <= IDLE;
         r_gnt      <= 1'b0;
         r_dividend <= '0;
         r_divisor  <= '0;
         r_quot     <= '0;
         r_rem      <= '0;
         r_err      <= 1'b0;
      end else begin
         r_state <= w_next_state;
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_gnt      <= w_gnt_id;
                  r_dividend <= w_dividend;
                  r_divisor  <= w_divisor;
                  if (w_div0) begin
                     r_quot <= DIV0_QUOT[WIDTH-1:0];
                     r_rem  <= w_dividend;
                     r_err  <= 1'b1;
                  end
               end
            end
            WAIT: begin
               // A completion in the timeout cycle still delivers the real result.
               if (div_done) begin
                  r_quot <= div_quot;
                  r_rem  <= div_rem;
                  r_err  <= 1'b0;
               end else if (w_timeout) begin
                  r_quot <= '0;
                  r_rem  <= '0;
                  r_err  <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign div_dividend = r_dividend;
   assign div_divisor  = r_divisor;
   assign rsp0_quot    = r_quot;
   assign rsp0_rem     = r_rem;
   assign rsp0_err     = r_err;
   assign rsp1_quot    = r_quot;
   assign rsp1_rem     = r_rem;
   assign rsp1_err     = r_err;
   assign o_dbg_state  = r_state;

endmodule
